// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding and control-FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OPC_ADD  = 3'd0,
        OPC_SUB  = 3'd1,
        OPC_MULT = 3'd2,
        OPC_DIV  = 3'd3,
        OPC_SL   = 3'd4,
        OPC_SR   = 3'd5
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Issue-side and writeback-side handshake bundle of the sequential ALU.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    opcode_t          in_opc;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_dz;

    modport slave (
        input  in_valid, in_signed, in_opc, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_dz
    );

    modport master (
        output in_valid, in_signed, in_opc, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_dz
    );

endinterface

// File: rtl/seq_alu_div_iter.sv
// Unsigned restoring divider, one quotient bit per clock; the first bit is
// resolved on the start edge so the quotient is complete WIDTH-1 edges later.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [2*WIDTH-1:0] w_first;
    logic [2*WIDTH-1:0] w_next;

    // Shift one dividend bit into the partial remainder and try to subtract.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] trial;
        logic           qbit;
        trial = {rem, quo[WIDTH-1]};
        qbit  = 1'b0;
        if (trial >= {1'b0, dvs}) begin
            trial = trial - {1'b0, dvs};
            qbit  = 1'b1;
        end
        return {trial[WIDTH-1:0], quo[WIDTH-2:0], qbit};
    endfunction

    assign w_first = div_step('0, dividend, divisor);
    assign w_next  = div_step(r_rem, r_quo, r_dvs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                {r_rem, r_quo} <= w_first;
                r_dvs          <= divisor;
                r_cnt          <= CNT_W'(WIDTH - 1);
            end else if (r_cnt != '0) begin
                {r_rem, r_quo} <= w_next;
                r_cnt          <= r_cnt - 1'b1;
                r_done         <= (r_cnt == CNT_W'(1));
            end
        end
    end

    assign busy     = (r_cnt != '0);
    assign done     = r_done;
    assign quotient = r_quo;

endmodule

// File: rtl/seq_alu.sv
// Handshaked signed/unsigned ALU: single-cycle ADD/SUB/MULT/shifts, iterative DIV,
// with overflow and divide-by-zero flags held until the consumer takes the result.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave io_bus
);
    localparam int SHIFT_W = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             ovf;
    } res_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_ovf;
    logic             r_out_dz;
    logic             r_div_neg;
    logic             r_div_dz;
    logic             r_div_ovf;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_acc;
    logic             w_is_div;
    logic             w_start;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_div_q;
    logic             w_div_busy;
    logic             w_div_done;
    logic             w_div_fin;
    res_t             w_alu;

    function automatic res_t alu_op(input opcode_t          opc,
                                    input logic             sgn,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        logic [WIDTH:0]     sum;
        logic [2*WIDTH-1:0] a_x, b_x, prod, sl_x;
        logic [WIDTH-1:0]   mask;
        logic [SHIFT_W-1:0] sh;
        res_t               r;
        r    = '0;
        sh   = b[SHIFT_W-1:0];
        sum  = {1'b0, a} + {1'b0, b};
        a_x  = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_x  = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod = a_x * b_x;
        sl_x = {{WIDTH{1'b0}}, a} << sh;
        // Low sh bits set: selects exactly the bits pushed out by the left shift.
        mask = ~({WIDTH{1'b1}} << sh);
        case (opc)
            OPC_ADD: begin
                r.data = sum[WIDTH-1:0];
                r.ovf  = sgn ? (a[WIDTH-1] == b[WIDTH-1] && r.data[WIDTH-1] != a[WIDTH-1])
                             : sum[WIDTH];
            end
            OPC_SUB: begin
                r.data = a - b;
                r.ovf  = sgn ? (a[WIDTH-1] != b[WIDTH-1] && r.data[WIDTH-1] != a[WIDTH-1])
                             : (a < b);
            end
            OPC_MULT: begin
                r.data = prod[WIDTH-1:0];
                r.ovf  = prod[2*WIDTH-1:WIDTH] != (sgn ? {WIDTH{r.data[WIDTH-1]}} : '0);
            end
            OPC_SL: begin
                r.data = sl_x[WIDTH-1:0];
                r.ovf  = sgn ? |((sl_x[2*WIDTH-1:WIDTH] ^ {WIDTH{r.data[WIDTH-1]}}) & mask)
                             : |sl_x[2*WIDTH-1:WIDTH];
            end
            OPC_SR: begin
                if (sgn) r.data = WIDTH'($signed(a) >>> sh);
                else     r.data = a >> sh;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    assign w_acc    = io_bus.in_valid && w_in_ready;
    assign w_is_div = (io_bus.in_opc == OPC_DIV);
    assign w_start  = w_acc && w_is_div;
    assign w_alu    = alu_op(io_bus.in_opc, io_bus.in_signed, io_bus.in_a, io_bus.in_b);
    assign w_mag_a  = (io_bus.in_signed && io_bus.in_a[WIDTH-1]) ? -io_bus.in_a : io_bus.in_a;
    assign w_mag_b  = (io_bus.in_signed && io_bus.in_b[WIDTH-1]) ? -io_bus.in_b : io_bus.in_b;
    assign w_div_fin = w_div_done && !w_div_busy;

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_mag_a),
        .divisor  (w_mag_b),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_acc) w_state_nxt = w_is_div ? ST_DIV_RUN : ST_DONE;
            ST_DIV_RUN: if (w_div_fin) w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (io_bus.out_ready) begin
                    if (w_acc) w_state_nxt = w_is_div ? ST_DIV_RUN : ST_DONE;
                    else       w_state_nxt = ST_IDLE;
                end
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready = 1'b1;
            ST_DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = io_bus.out_ready;
            end
            default: ;
        endcase
        if (rst) w_in_ready = 1'b0;
    end

    // Result registers only load on an accept or a divider finish, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
            r_out_dz   <= 1'b0;
            r_div_neg  <= 1'b0;
            r_div_dz   <= 1'b0;
            r_div_ovf  <= 1'b0;
        end else begin
            if (w_acc && !w_is_div) begin
                r_out_data <= w_alu.data;
                r_out_ovf  <= w_alu.ovf;
                r_out_dz   <= 1'b0;
            end
            if (w_start) begin
                r_div_neg <= io_bus.in_signed && (io_bus.in_a[WIDTH-1] ^ io_bus.in_b[WIDTH-1]);
                r_div_dz  <= (io_bus.in_b == '0);
                r_div_ovf <= io_bus.in_signed && (io_bus.in_a == {1'b1, {(WIDTH-1){1'b0}}})
                             && (io_bus.in_b == '1);
            end
            if (r_state == ST_DIV_RUN && w_div_fin) begin
                r_out_data <= r_div_dz ? '1 : (r_div_neg ? -w_div_q : w_div_q);
                r_out_ovf  <= r_div_ovf;
                r_out_dz   <= r_div_dz;
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_ovf   = r_out_ovf;
    assign io_bus.out_dz    = r_out_dz;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8 with an arithmetic reference model and scoreboard.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       o;
        logic       z;
    } res_t;

    typedef struct {
        res_t r;
        int   due;
        bit   seen;
        bit   late;
    } ent_t;

    typedef struct {
        opcode_t    op;
        bit         s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        bit         o;
        bit         z;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   e = 0;
    ent_t q[$];
    vec_t vecs[19];

    seq_alu_if #(.WIDTH(W)) bus();

    seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Exact integer result, wrapped to 8 bits; overflow means the exact value is out of range.
    function automatic res_t model(input opcode_t op, input bit s,
                                   input logic [7:0] a, input logic [7:0] b);
        longint sa, sb, r, lo, hi;
        int     sh;
        res_t   m;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lo = -128;
            hi = 127;
        end else begin
            sa = longint'(a);
            sb = longint'(b);
            lo = 0;
            hi = 255;
        end
        sh = int'(b[2:0]);
        m  = '0;
        r  = 0;
        case (op)
            OPC_ADD:  r = sa + sb;
            OPC_SUB:  r = sa - sb;
            OPC_MULT: r = sa * sb;
            OPC_SL:   r = sa * (longint'(1) << sh);
            OPC_SR:   r = sa >>> sh;
            OPC_DIV: begin
                if (sb == 0) begin
                    m.z = 1'b1;
                    r   = 255;
                end else begin
                    r = sa / sb;
                end
            end
            default:  r = 0;
        endcase
        m.d = r[7:0];
        m.o = !m.z && (r < lo || r > hi);
        return m;
    endfunction

    always @(posedge clk) begin : monitor
        ent_t ent;
        e++;
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                ent.r    = model(bus.in_opc, bus.in_signed, bus.in_a, bus.in_b);
                ent.due  = e + ((bus.in_opc == OPC_DIV) ? W : 0);
                ent.seen = 1'b0;
                ent.late = 1'b0;
                q.push_back(ent);
            end
        end
    end

    always @(negedge clk) begin : compare
        ent_t t;
        if (!rst) begin
            if (q.size() > 0) begin
                t = q[0];
                if (bus.out_valid) begin
                    chk("model_result", {bus.out_data, bus.out_ovf, bus.out_dz}, t.r);
                    if (!t.seen) begin
                        chk("model_latency", e, t.due);
                        t.seen = 1'b1;
                    end
                end else if (e > t.due && !t.late) begin
                    total++;
                    bad++;
                    $display("FAIL model_late: no out_valid at edge %0d, due at %0d", e, t.due);
                    t.late = 1'b1;
                end
                q[0] = t;
            end else if (bus.out_valid) begin
                total++;
                bad++;
                $display("FAIL model_spurious: out_valid=1 with no outstanding operation");
            end
        end
    end

    task automatic drive(input opcode_t op, input bit s, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid  = 1'b1;
        bus.in_opc    = op;
        bus.in_signed = s;
        bus.in_a      = a;
        bus.in_b      = b;
    endtask

    task automatic do_op(input int idx);
        vec_t v;
        int   n;
        int   lat;
        bit   rdy;
        bit   ir_bad;
        v   = vecs[idx];
        lat = (v.op == OPC_DIV) ? W + 1 : 1;
        @(posedge clk);
        #1 drive(v.op, v.s, v.a, v.b);
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            n++;
        end
        #1 bus.in_valid = 1'b0;
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL vec%0d_accept: in_ready stayed 0 for %0d cycles", idx, n);
        end
        n      = 0;
        ir_bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.out_valid && bus.in_ready) ir_bad = 1'b1;
        end while (!bus.out_valid && n < 30);
        chk($sformatf("vec%0d_latency", idx), n, lat);
        chk($sformatf("vec%0d_result", idx), {bus.out_data, bus.out_ovf, bus.out_dz}, {v.d, v.o, v.z});
        if (v.op == OPC_DIV) chk($sformatf("vec%0d_busy_ready", idx), ir_bad, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] sa[4];
        logic [7:0] sb[4];
        logic [9:0] sx[4];
        bit         seen_valid;

        vecs[0]  = '{OPC_ADD,  1'b0, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0};
        vecs[1]  = '{OPC_ADD,  1'b1, 8'd100, 8'd50,  8'h96, 1'b1, 1'b0};
        vecs[2]  = '{OPC_MULT, 1'b1, 8'hFD,  8'h05,  8'hF1, 1'b0, 1'b0};
        vecs[3]  = '{OPC_MULT, 1'b0, 8'h10,  8'h10,  8'h00, 1'b1, 1'b0};
        vecs[4]  = '{OPC_SR,   1'b1, 8'h80,  8'h03,  8'hF0, 1'b0, 1'b0};
        vecs[5]  = '{OPC_SR,   1'b0, 8'h80,  8'h03,  8'h10, 1'b0, 1'b0};
        vecs[6]  = '{OPC_DIV,  1'b1, 8'hF9,  8'h02,  8'hFD, 1'b0, 1'b0};
        vecs[7]  = '{OPC_DIV,  1'b0, 8'hFF,  8'h10,  8'h0F, 1'b0, 1'b0};
        vecs[8]  = '{OPC_DIV,  1'b0, 8'h05,  8'h00,  8'hFF, 1'b0, 1'b1};
        vecs[9]  = '{OPC_DIV,  1'b1, 8'h80,  8'hFF,  8'h80, 1'b1, 1'b0};
        vecs[10] = '{opcode_t'(3'd6), 1'b1, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{OPC_SL,   1'b0, 8'hA5,  8'h00,  8'hA5, 1'b0, 1'b0};
        vecs[12] = '{OPC_SUB,  1'b0, 8'h03,  8'h05,  8'hFE, 1'b1, 1'b0};
        vecs[13] = '{OPC_SL,   1'b1, 8'h40,  8'h01,  8'h80, 1'b1, 1'b0};
        vecs[14] = '{OPC_SL,   1'b1, 8'hC0,  8'h01,  8'h80, 1'b0, 1'b0};
        vecs[15] = '{OPC_SUB,  1'b1, 8'h80,  8'h01,  8'h7F, 1'b1, 1'b0};
        vecs[16] = '{OPC_DIV,  1'b1, 8'h64,  8'hF9,  8'hF2, 1'b0, 1'b0};
        vecs[17] = '{OPC_DIV,  1'b1, 8'hF9,  8'h00,  8'hFF, 1'b0, 1'b1};
        vecs[18] = '{OPC_SL,   1'b0, 8'h81,  8'h01,  8'h02, 1'b1, 1'b0};

        sa = '{8'h01, 8'h03, 8'h05, 8'hF0};
        sb = '{8'h02, 8'h04, 8'h06, 8'h20};
        sx = '{{8'h03, 2'b00}, {8'h07, 2'b00}, {8'h0B, 2'b00}, {8'h10, 2'b10}};

        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_opc    = OPC_ADD;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        chk("pin_model_add",  model(OPC_ADD, 1'b0, 8'd200, 8'd100), {8'h2C, 1'b1, 1'b0});
        chk("pin_model_div",  model(OPC_DIV, 1'b1, 8'hF9, 8'h02),   {8'hFD, 1'b0, 1'b0});
        chk("pin_model_sl",   model(OPC_SL,  1'b1, 8'h40, 8'h01),   {8'h80, 1'b1, 1'b0});
        chk("pin_model_dz",   model(OPC_DIV, 1'b1, 8'hF9, 8'h00),   {8'hFF, 1'b0, 1'b1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {bus.out_valid, bus.out_data, bus.out_ovf, bus.out_dz, bus.in_ready},
            {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});

        for (int i = 0; i < 19; i++) do_op(i);

        // Hold the writeback side for 5 cycles with a new operation waiting.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        drive(OPC_ADD, 1'b0, 8'h11, 8'h22);
        @(negedge clk);
        chk("bp_idle_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 drive(OPC_ADD, 1'b0, sa[0], sb[0]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i),
                {bus.out_valid, bus.out_data, bus.out_ovf, bus.out_dz, bus.in_ready},
                {1'b1, 8'h33, 1'b0, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stream_ready%0d", i), bus.in_ready, 1);
            if (i > 0)
                chk($sformatf("stream_res%0d", i - 1),
                    {bus.out_valid, bus.out_data, bus.out_ovf, bus.out_dz}, {1'b1, sx[i-1]});
            @(posedge clk);
            #1;
            if (i < 3) drive(OPC_ADD, 1'b0, sa[i+1], sb[i+1]);
            else       bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("stream_res3", {bus.out_valid, bus.out_data, bus.out_ovf, bus.out_dz}, {1'b1, sx[3]});

        // Reset lands on the fourth DIV_RUN cycle.
        @(posedge clk);
        #1 drive(OPC_DIV, 1'b0, 8'd100, 8'd3);
        @(negedge clk);
        chk("rdiv_accept_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rdiv_rst_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rdiv_cleared", {bus.out_valid, bus.out_data, bus.out_ovf, bus.out_dz, bus.in_ready},
            {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk("rdiv_no_result", seen_valid, 0);
        do_op(0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
